// File: rtl/im_port_arbiter.sv
// Single-port instruction-memory arbiter: fetch reads vs. program-loader writes,
// with text-segment address translation, legality checks and loader anti-starvation.
module im_port_arbiter #(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_3000,
    parameter int unsigned IM_HIGH      = 11,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_gnt,
    output logic               fetch_valid,
    output logic [31:0]        fetch_rdata,
    output logic               fetch_err,
    input  logic               load_req,
    input  logic [31:0]        load_addr,
    input  logic [31:0]        load_wdata,
    output logic               load_gnt,
    output logic               load_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [IM_HIGH-2:0] mem_idx,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam int unsigned IDX_W = IM_HIGH - 1;
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    // Addresses below the base wrap to a huge offset and fail the range test.
    function automatic logic addr_legal(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (addr >= ADDR_BASE) && ((off >> (IM_HIGH + 1)) == 32'd0)
               && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[IM_HIGH:2];
    endfunction

    logic [3:0] starve_q, starve_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_err_q, rd_err_d;
    logic       load_err_q, load_err_d;
    logic       fetch_legal, load_legal, load_forced;

    always_comb begin
        fetch_legal = addr_legal(fetch_addr);
        load_legal  = addr_legal(load_addr);
        load_forced = load_req && (starve_q == LIMIT);

        fetch_gnt = !reset && fetch_req && !load_forced;
        load_gnt  = !reset && load_req && (!fetch_req || load_forced);

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        if (fetch_gnt && fetch_legal) begin
            mem_en  = 1'b1;
            mem_idx = addr_idx(fetch_addr);
        end else if (load_gnt && load_legal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_idx   = addr_idx(load_addr);
            mem_wdata = load_wdata;
        end

        if (load_req && !load_gnt)
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
        else
            starve_d = '0;

        rd_pend_d  = fetch_gnt;
        rd_err_d   = fetch_gnt && !fetch_legal;
        load_err_d = load_gnt && !load_legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_err_q   <= rd_err_d;
            load_err_q <= load_err_d;
        end
    end

    // Reset masks results already in flight so a read granted just before reset never surfaces.
    always_comb begin
        fetch_valid = rd_pend_q && !reset;
        fetch_err   = rd_err_q && !reset;
        load_err    = load_err_q && !reset;
        fetch_rdata = (fetch_valid && !rd_err_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed self-checking bench for im_port_arbiter with a behavioural
// synchronous single-port RAM attached to the memory side.
module tb_im_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, load_req;
    logic [31:0] fetch_addr, load_addr, load_wdata;
    logic        fetch_gnt, fetch_valid, fetch_err, load_gnt, load_err;
    logic [31:0] fetch_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_idx;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] ram [0:1023];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    im_port_arbiter #(
        .ADDR_BASE(32'h0000_3000),
        .IM_HIGH(11),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_err(load_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_idx] <= mem_wdata;
            else        mem_rdata   <= ram[mem_idx];
        end
    end

    // Advance to just after the next rising edge; callers then drive and settle.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        fetch_req = 1'b0; load_req = 1'b0;
        fetch_addr = 32'd0; load_addr = 32'd0; load_wdata = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h3000;
        load_req = 1'b1; load_addr = 32'h3004; load_wdata = 32'h1234_5678;
        repeat (3) next_cycle();
        #1;
        checks++; if (fetch_gnt !== 1'b0) begin failures++; $display("FAIL rst_fetch_gnt got=%b exp=0", fetch_gnt); end
        checks++; if (load_gnt !== 1'b0) begin failures++; $display("FAIL rst_load_gnt got=%b exp=0", load_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b%b exp=00", mem_en, mem_we); end
        checks++; if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL rst_regs got=%b%b%b exp=000", fetch_valid, fetch_err, load_err); end
        next_cycle();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_release_valid got=%b exp=0", fetch_valid); end
    endtask

    task automatic test_fetch;
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 32'h3000; #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL f0_gnt got=%b%b%b exp=110", fetch_gnt, mem_en, mem_we); end
        checks++; if (mem_idx !== 10'd0) begin failures++; $display("FAIL f0_idx got=%0d exp=0", mem_idx); end
        next_cycle();
        fetch_addr = 32'h3004; #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_idx !== 10'd1) begin failures++; $display("FAIL f1_gnt got=%b/%0d exp=1/1", fetch_gnt, mem_idx); end
        checks++; if (fetch_valid !== 1'b1 || fetch_rdata !== 32'h2408_0001 || fetch_err !== 1'b0) begin failures++; $display("FAIL f0_data got=%b/%h/%b exp=1/24080001/0", fetch_valid, fetch_rdata, fetch_err); end
        next_cycle();
        idle(); #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_rdata !== 32'h0000_000C || fetch_err !== 1'b0) begin failures++; $display("FAIL f1_data got=%b/%h/%b exp=1/0000000c/0", fetch_valid, fetch_rdata, fetch_err); end
        next_cycle(); #1;
        checks++; if (fetch_valid !== 1'b0 || fetch_rdata !== 32'd0) begin failures++; $display("FAIL f_idle got=%b/%h exp=0/0", fetch_valid, fetch_rdata); end
    endtask

    task automatic test_write_read;
        next_cycle();
        load_req = 1'b1; load_addr = 32'h3010; load_wdata = 32'hDEAD_BEEF; #1;
        checks++; if (load_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b%b%b exp=111", load_gnt, mem_en, mem_we); end
        checks++; if (mem_idx !== 10'd4 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_idx got=%0d/%h exp=4/deadbeef", mem_idx, mem_wdata); end
        next_cycle();
        idle(); fetch_req = 1'b1; fetch_addr = 32'h3010; #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_idx !== 10'd4) begin failures++; $display("FAIL rd_gnt got=%b/%0d exp=1/4", fetch_gnt, mem_idx); end
        next_cycle();
        idle(); #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%b/%h exp=1/deadbeef", fetch_valid, fetch_rdata); end
    endtask

    task automatic test_starvation;
        logic exp_load, prev_fetch;
        prev_fetch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            fetch_req = 1'b1; fetch_addr = 32'h3000;
            load_req = 1'b1; load_addr = 32'h3020; load_wdata = 32'h5555_0000 + 32'(k);
            #1;
            exp_load = (k == 4) || (k == 9);
            checks++; if (load_gnt !== exp_load || fetch_gnt !== !exp_load) begin failures++; $display("FAIL starve_k%0d got=f%b/l%b exp=f%b/l%b", k, fetch_gnt, load_gnt, !exp_load, exp_load); end
            checks++; if (fetch_valid !== prev_fetch) begin failures++; $display("FAIL starve_valid_k%0d got=%b exp=%b", k, fetch_valid, prev_fetch); end
            prev_fetch = !exp_load;
        end
        next_cycle();
        idle(); #1;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL starve_tail_valid got=%b exp=0", fetch_valid); end
        checks++; if (ram[8] !== 32'h5555_0009) begin failures++; $display("FAIL starve_write got=%h exp=55550009", ram[8]); end
    endtask

    task automatic test_illegal;
        next_cycle();
        load_req = 1'b1; load_addr = 32'h2FFC; load_wdata = 32'hBAD0_0001; #1;
        checks++; if (load_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL ld_low_gnt got=%b/%b exp=1/0", load_gnt, mem_en); end
        next_cycle();
        idle(); #1;
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL ld_low_err got=%b exp=1", load_err); end
        next_cycle(); #1;
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL ld_err_pulse got=%b exp=0", load_err); end
        // Two illegal writes back to back give two consecutive pulses.
        load_req = 1'b1; load_addr = 32'h2FFC; #1;
        next_cycle();
        load_addr = 32'h3001; #1;
        checks++; if (load_gnt !== 1'b1 || mem_en !== 1'b0 || load_err !== 1'b1) begin failures++; $display("FAIL ld_b2b_a got=%b%b%b exp=101", load_gnt, mem_en, load_err); end
        next_cycle();
        idle(); #1;
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL ld_b2b_b got=%b exp=1", load_err); end
        next_cycle(); #1;
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL ld_b2b_end got=%b exp=0", load_err); end

        fetch_req = 1'b1; fetch_addr = 32'h3002; #1;
        checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL f_mis_gnt got=%b/%b exp=1/0", fetch_gnt, mem_en); end
        next_cycle();
        fetch_addr = 32'h4000; #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_rdata !== 32'd0) begin failures++; $display("FAIL f_mis_resp got=%b/%b/%h exp=1/1/0", fetch_valid, fetch_err, fetch_rdata); end
        checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL f_hi_gnt got=%b/%b exp=1/0", fetch_gnt, mem_en); end
        next_cycle();
        fetch_addr = 32'h3FFC; #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_rdata !== 32'd0) begin failures++; $display("FAIL f_hi_resp got=%b/%b/%h exp=1/1/0", fetch_valid, fetch_err, fetch_rdata); end
        checks++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_idx !== 10'd1023) begin failures++; $display("FAIL f_top_gnt got=%b/%b/%0d exp=1/1/1023", fetch_gnt, mem_en, mem_idx); end
        next_cycle();
        idle(); #1;
        checks++; if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_rdata !== 32'h7777_0001) begin failures++; $display("FAIL f_top_resp got=%b/%b/%h exp=1/0/77770001", fetch_valid, fetch_err, fetch_rdata); end
    endtask

    task automatic test_reset_mid;
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 32'h3000; #1;
        checks++; if (fetch_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b exp=1", fetch_gnt); end
        next_cycle();
        reset = 1'b1; load_req = 1'b1; load_addr = 32'h3000; #1;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rm_valid_n1 got=%b exp=0", fetch_valid); end
        checks++; if (fetch_gnt !== 1'b0 || load_gnt !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL rm_no_gnt got=%b%b%b exp=000", fetch_gnt, load_gnt, mem_en); end
        next_cycle();
        reset = 1'b0; idle(); #1;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rm_valid_n2 got=%b exp=0", fetch_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [0:19];
        for (int i = 0; i < 20; i++) begin
            words[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
            next_cycle();
            load_req = 1'b1; load_addr = 32'h3000 + 32'(4 * i); load_wdata = words[i]; #1;
            checks++; if (load_gnt !== 1'b1 || mem_we !== 1'b1 || mem_idx !== 10'(i)) begin failures++; $display("FAIL b2b_wr%0d got=%b/%b/%0d exp=1/1/%0d", i, load_gnt, mem_we, mem_idx, i); end
        end
        for (int i = 0; i <= 20; i++) begin
            next_cycle();
            idle();
            if (i < 20) begin fetch_req = 1'b1; fetch_addr = 32'h3000 + 32'(4 * i); end
            #1;
            if (i > 0) begin
                checks++; if (fetch_valid !== 1'b1 || fetch_rdata !== words[i-1]) begin failures++; $display("FAIL b2b_rd%0d got=%b/%h exp=1/%h", i - 1, fetch_valid, fetch_rdata, words[i-1]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[0]    = 32'h2408_0001;
        ram[1]    = 32'h0000_000C;
        ram[1023] = 32'h7777_0001;
        idle();
        test_reset();
        test_fetch();
        test_write_read();
        test_starvation();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
